// File: rtl/ripple_adder_pkg.sv
// ripple_adder_pkg: shared constants for the ripple adder
package ripple_adder_pkg;
  localparam int RIPPLE_ADDER_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/ripple_adder_full_adder.sv
// full_adder: single-bit combinational full-adder cell
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/ripple_adder.sv
// ripple_adder: registered ripple-carry adder; RIPPLE_ADDER_OVF_EN adds a registered signed-overflow flag
module ripple_adder
  import ripple_adder_pkg::*;
#(
  parameter int WIDTH = RIPPLE_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
`ifdef RIPPLE_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             valid
);
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q;
  assign carry[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder u_fa (
      .a (a[i]),
      .b (b[i]),
      .ci(carry[i]),
      .s (sum[i]),
      .co(carry[i+1])
    );
  end
  // load a fresh result on en, otherwise hold the last one
  always_comb begin
    s_d    = en ? sum : s_q;
    cout_d = en ? carry[WIDTH] : cout_q;
  end
  // result registers; reset wins over en and discards that edge's operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= en;
    end
  end
  assign s     = s_q;
  assign cout  = cout_q;
  assign valid = valid_q;
`ifdef RIPPLE_ADDER_OVF_EN
  logic ovf_q, ovf_d;
  // overflow when like-signed operands produce a result of the other sign
  always_comb begin
    ovf_d = en ? ((a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1])) : ovf_q;
  end
  // overflow register follows the same reset/en rules as the sum
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_ripple_adder.sv
// tb_ripple_adder: randomized self-checking bench for ripple_adder against an arithmetic model
module tb_ripple_adder;
  localparam int W = 4;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         valid;
`ifdef RIPPLE_ADDER_OVF_EN
  logic         ovf;
`endif
  logic [W-1:0] exp_s = '0;
  logic         exp_c = 1'b0;
  logic         exp_v = 1'b0;
  logic         exp_o = 1'b0;
  int           checks = 0;
  int           errors = 0;

  ripple_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout),
`ifdef RIPPLE_ADDER_OVF_EN
    .ovf  (ovf),
`endif
    .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    int t, sa, sb, r;
    t  = int'(a) + int'(b) + int'(cin);
    sa = (int'(a) >= 8) ? int'(a) - 16 : int'(a);
    sb = (int'(b) >= 8) ? int'(b) - 16 : int'(b);
    r  = sa + sb + int'(cin);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      exp_s = '0; exp_c = 0; exp_v = 0; exp_o = 0;
    end else begin
      exp_v = en;
      if (en) begin
        exp_s = t[W-1:0];
        exp_c = t[W];
        exp_o = (r > 7) || (r < -8);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 0; en = 1; a = 4'hF; b = 4'hF; cin = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (s !== 4'h0 || cout !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL reset edge%0d s=%h cout=%b valid=%b expected 0/0/0", k, s, cout, valid);
      end
`ifdef RIPPLE_ADDER_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf ovf=%b expected 0", ovf); end
`endif
    end
    rst_n = 1;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      en = 1; a = W'(i); b = W'(i); cin = 0;
      tick();
      checks++;
      if (s !== exp_s || cout !== exp_c || valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep i=%0d s=%h cout=%b valid=%b expected %h/%b/1", i, s, cout, valid, exp_s, exp_c);
      end
    end
  endtask

  task automatic test_wrap();
    en = 1; a = 4'hF; b = 4'h0; cin = 1;
    tick();
    checks++;
    if (s !== 4'h0 || cout !== 1'b1) begin
      errors++; $display("FAIL wrap_f s=%h cout=%b expected 0/1", s, cout);
    end
    a = 4'h0; b = 4'h0; cin = 1;
    tick();
    checks++;
    if (s !== 4'h1 || cout !== 1'b0) begin
      errors++; $display("FAIL wrap_0 s=%h cout=%b expected 1/0", s, cout);
    end
  endtask

  task automatic test_hold();
    en = 1; a = 4'd3; b = 4'd4; cin = 0;
    tick();
    en = 0; a = 4'd9; b = 4'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (s !== 4'h7 || valid !== 1'b0 || cout !== exp_c) begin
        errors++; $display("FAIL hold edge%0d s=%h valid=%b expected 7/0", k, s, valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1; a = 4'd6; b = 4'd6; cin = 0; rst_n = 0;
    tick();
    checks++;
    if (s !== 4'h0 || valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid s=%h valid=%b expected 0/0", s, valid);
    end
    rst_n = 1;
    tick();
    checks++;
    if (s !== 4'hC || valid !== 1'b1 || cout !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after s=%h valid=%b cout=%b expected c/1/0", s, valid, cout);
    end
  endtask

  task automatic test_sync_reset();
    en = 1; a = 4'h5; b = 4'h2; cin = 0;
    tick();
    en = 0;
    rst_n = 0;
    #2;
    checks++;
    if (s !== 4'h7 || valid !== 1'b1) begin
      errors++; $display("FAIL sync_rst s=%h valid=%b expected 7/1", s, valid);
    end
    rst_n = 1;
    tick();
    checks++;
    if (s !== 4'h7 || valid !== 1'b0) begin
      errors++; $display("FAIL sync_rst_hold s=%h valid=%b expected 7/0", s, valid);
    end
  endtask

`ifdef RIPPLE_ADDER_OVF_EN
  task automatic test_ovf();
    en = 1; a = 4'h7; b = 4'h1; cin = 0;
    tick();
    checks++;
    if (s !== 4'h8 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_pos s=%h ovf=%b expected 8/1", s, ovf);
    end
    a = 4'hF; b = 4'h1;
    tick();
    checks++;
    if (s !== 4'h0 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL ovf_neg s=%h cout=%b ovf=%b expected 0/1/0", s, cout, ovf);
    end
  endtask
`endif

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst_n = $urandom_range(0, 15) != 0;
      en    = $urandom_range(0, 3) != 0;
      a     = W'($urandom_range(0, 15));
      b     = W'($urandom_range(0, 15));
      cin   = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (s !== exp_s || cout !== exp_c || valid !== exp_v) begin
        errors++;
        $display("FAIL random k=%0d s=%h cout=%b valid=%b expected %h/%b/%b", k, s, cout, valid, exp_s, exp_c, exp_v);
      end
`ifdef RIPPLE_ADDER_OVF_EN
      checks++;
      if (ovf !== exp_o) begin
        errors++; $display("FAIL random_ovf k=%0d ovf=%b expected %b", k, ovf, exp_o);
      end
`endif
    end
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_sync_reset();
`ifdef RIPPLE_ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ripple_adder.md
RIPPLE_ADDER -- requirements
Module: ripple_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits (legal range 1..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  load strobe; operands are sampled on a rising clk edge where en=1.
REQ-005 a  input  WIDTH  operand A, unsigned.
REQ-006 b  input  WIDTH  operand B, unsigned.
REQ-007 cin  input  1  carry into bit 0.
REQ-008 s  output  WIDTH  registered sum.
REQ-009 cout  output  1  registered carry out of bit WIDTH-1.
REQ-010 valid  output  1  high for exactly the cycles whose s/cout reflect an en=1 sample from the previous edge.
REQ-011 ovf  output  1  registered two's-complement overflow; present only when RIPPLE_ADDER_OVF_EN is defined.

Function
REQ-012 The combinational sum SHALL be formed by a chain of WIDTH full-adder cells, with carry[0]=cin and carry[i+1] being the carry out of cell i; no behavioural '+' on the full vector.
REQ-013 Each cell: sum_i = a_i XOR b_i XOR c_i; c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)).
REQ-014 {cout, s} SHALL equal a + b + cin evaluated at WIDTH+1 bits; s wraps modulo 2^WIDTH.
REQ-015 Latency: the result of operands sampled at edge N SHALL appear on s/cout after edge N and remain stable until the next en=1 edge.
REQ-016 On edges where en=0, s, cout and ovf SHALL hold their values, and valid SHALL be 0 after that edge.
REQ-017 valid SHALL equal en registered: it is 1 after every edge with en=1 and rst_n=1, including back-to-back cycles (throughput one result per cycle).
REQ-018 No X propagation: with all inputs known, all outputs SHALL be known after the first reset.

Reset
REQ-019 When rst_n=0 at a rising clk edge, s=0, cout=0, valid=0 and ovf=0 after that edge, regardless of en.
REQ-020 Reset SHALL take priority over en; assertion mid-stream SHALL discard the operation sampled at that edge.
REQ-021 Outputs SHALL be unaffected by rst_n between clock edges (synchronous reset only).

Configuration
REQ-022 Macro RIPPLE_ADDER_OVF_EN defined: port ovf exists and is loaded with (a[W-1] == b[W-1]) AND (s_next[W-1] != a[W-1]) under the same en/reset rules as s.
REQ-023 Macro RIPPLE_ADDER_OVF_EN undefined: port ovf and its register SHALL be absent; all other behaviour is unchanged.

Structure
REQ-024 A package ripple_adder_pkg SHALL hold the default-width constant RIPPLE_ADDER_DEFAULT_WIDTH = 4, used as WIDTH's default.
REQ-025 A sub-module full_adder (inputs a, b, ci; outputs s, co; purely combinational) SHALL implement REQ-013 and be instantiated WIDTH times through a generate loop.
REQ-026 ripple_adder SHALL contain only the carry chain, the output registers and the optional overflow logic.

Verification
REQ-027 Reset: rst_n=0 for 2 edges with en=1, a=4'hF, b=4'hF -> s=0, cout=0, valid=0.
REQ-028 Sweep: i=0..15, a=b=i, cin=0, en=1 -> one edge later s=(2*i) mod 16, cout=(i>=8), valid=1 (e.g. i=5 -> s=4'hA, cout=0; i=15 -> s=4'hE, cout=1).
REQ-029 Carry-chain wrap: a=4'hF, b=4'h0, cin=1 -> s=4'h0, cout=1; a=4'h0, b=4'h0, cin=1 -> s=4'h1, cout=0.
REQ-030 Hold: load a=3, b=4, cin=0, then en=0 with a=9, b=9 for 3 edges -> s stays 4'h7, valid=0.
REQ-031 Reset mid-stream: en=1 with a=6, b=6 while rst_n=0 on the same edge -> s=0, valid=0; the next edge with rst_n=1 gives s=4'hC.
REQ-032 With RIPPLE_ADDER_OVF_EN: a=4'h7, b=4'h1, cin=0 -> s=4'h8, ovf=1; a=4'hF, b=4'h1 -> s=0, cout=1, ovf=0.
